tensor_window_seq: RTL and testbench

- Sequences the sliding-window position for the 8-slice tensor core.
- Drives cfg_reg[31:26]: X = 0..9 (inner loop) and Y = 0..3 (outer loop), giving 40 windows per pass.
- Waits the slice pipeline latency at each position, then captures the 8x8-bit tnsout vector tagged with its position into an output FIFO.
- Streams results downstream over a valid/ready interface and signals completion with a done pulse.

---
 rtl/tensor_pkg.sv | 11 +
 rtl/tensor_out_fifo.sv | 34 +++
 rtl/tensor_window_seq.sv | 104 ++++++++++
 tb/tb_tensor_window_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tensor_pkg.sv
// tensor_pkg: shared window-sequencer constants and FSM state encoding
package tensor_pkg;
  localparam int WND_X_LAST  = 9;
  localparam int WND_Y_LAST  = 3;
  localparam int CFG_X_MSB   = 31;
  localparam int CFG_X_LSB   = 28;
  localparam int CFG_Y_MSB   = 27;
  localparam int CFG_Y_LSB   = 26;
  localparam int SLICE_CFG_W = 26;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/tensor_out_fifo.sv
// tensor_out_fifo: show-ahead sync FIFO; ports clk/rst(async low), push/push_data, pop, head, full, empty
module tensor_out_fifo #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr, rd;
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign head  = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/tensor_window_seq.sv
// tensor_window_seq: steps X/Y window over tensor core, captures tnsout into FIFO; ports start/slice_cfg in, cfg_reg out, tnsout in, out_data/out_valid/out_ready stream, busy/done
module tensor_window_seq
  import tensor_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32,
  parameter int TENSOR_WIDTH = 8,
  parameter int TENSOR_SLICE = 8,
  parameter int X_LAST       = WND_X_LAST,
  parameter int Y_LAST       = WND_Y_LAST,
  parameter int PIPE_LAT     = 2,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [SLICE_CFG_W-1:0]               slice_cfg,
  output logic [CONFIG_WIDTH-1:0]              cfg_reg,
  input  logic [TENSOR_SLICE*TENSOR_WIDTH-1:0] tnsout,
  output logic [TENSOR_SLICE*TENSOR_WIDTH+5:0] out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 done
);
  state_t                 state, state_d;
  logic [3:0]             x, x_d, cnt, cnt_d;
  logic [1:0]             y, y_d;
  logic [SLICE_CFG_W-1:0] cfg_l, cfg_d;
  logic                   done_d, push, full, empty, x_end, y_end;
  assign x_end = x == 4'(X_LAST);
  assign y_end = y == 2'(Y_LAST);
  assign cfg_reg[CFG_X_MSB:CFG_X_LSB]   = x;
  assign cfg_reg[CFG_Y_MSB:CFG_Y_LSB]   = y;
  assign cfg_reg[SLICE_CFG_W-1:0]       = cfg_l;
  assign busy      = state != IDLE;
  assign out_valid = !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      cfg_l <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      x     <= x_d;
      y     <= y_d;
      cnt   <= cnt_d;
      cfg_l <= cfg_d;
      done  <= done_d;
    end
  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    cnt_d   = cnt;
    cfg_d   = cfg_l;
    push    = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          cfg_d   = slice_cfg;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = 4'(PIPE_LAT);
          state_d = WAIT;
        end
      WAIT: begin
        cnt_d   = cnt - 1'b1;
        state_d = cnt == 4'd1 ? CAPTURE : WAIT;
      end
      CAPTURE:
        if (!full) begin
          push    = 1'b1;
          cnt_d   = 4'(PIPE_LAT);
          state_d = x_end && y_end ? DRAIN : WAIT;
          // the final window keeps its position so cfg_reg holds it through DRAIN/IDLE
          x_d     = x_end ? (y_end ? x : '0) : x + 1'b1;
          y_d     = x_end && !y_end ? y + 1'b1 : y;
        end
      DRAIN:
        if (empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  tensor_out_fifo #(
    .WIDTH(TENSOR_SLICE*TENSOR_WIDTH+6),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({y, x, tnsout}),
    .pop      (out_ready),
    .head     (out_data),
    .full     (full),
    .empty    (empty)
  );
endmodule

// File: tb/tb_tensor_window_seq.sv
// tb_tensor_window_seq: directed self-checking bench for tensor_window_seq
module tb_tensor_window_seq;
  logic        clk = 1'b0;
  logic        rst, start, out_ready, busy, done, out_valid;
  logic [25:0] slice_cfg;
  logic [31:0] cfg_reg;
  logic [63:0] tnsout;
  logic [69:0] out_data;
  logic [5:0]  p0, p1;
  logic [69:0] got[$];
  int          errors = 0, checks = 0, cyc = 0, dones = 0, done_cyc = 0, e0 = 0;
  bit          ok;
  localparam logic [25:0] CFG_A = 26'h2abcdef;
  localparam logic [25:0] CFG_B = 26'h1234567;
  always #5 clk = ~clk;
  tensor_window_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .slice_cfg(slice_cfg),
    .cfg_reg  (cfg_reg),
    .tnsout   (tnsout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );
  function automatic logic [63:0] tns_of(logic [5:0] pos);
    logic [7:0] b;
    b = {2'b10, pos[1:0], pos[5:2]};
    return {8{b}};
  endfunction
  function automatic logic [69:0] exp_entry(int n);
    logic [3:0] x;
    logic [1:0] y;
    x = 4'(n % 10);
    y = 2'(n / 10);
    return {y, x, tns_of({x, y})};
  endfunction
  // two-stage core model: tnsout only shows a position after it has been stable for PIPE_LAT edges
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p0  <= cfg_reg[31:26];
    p1  <= p0;
  end
  assign tnsout = tns_of(p1);
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) begin
      dones    <= dones + 1;
      done_cyc <= cyc;
    end
  end
  task automatic chk(string tag, logic [69:0] obs, logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_start(logic [25:0] c);
    @(posedge clk);
    #1;
    got.delete();
    dones     = 0;
    slice_cfg = c;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
  endtask
  task automatic wait_done(string tag, int budget);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    chk({tag, "_done_seen"}, 70'(ok), 70'd1);
    @(negedge clk);
  endtask
  task automatic wait_pos(string tag, logic [5:0] pos, int budget);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cfg_reg[31:26] == pos) ok = 1;
    end
    chk({tag, "_pos_seen"}, 70'(ok), 70'd1);
  endtask
  task automatic check_stream(string tag);
    chk({tag, "_count"}, 70'(got.size()), 70'd40);
    for (int n = 0; n < 40 && n < got.size(); n++)
      chk($sformatf("%s_entry%0d", tag, n), got[n], exp_entry(n));
  endtask
  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    slice_cfg = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_cfg_reg", 70'(cfg_reg), 70'd0);
    chk("rst_busy", 70'(busy), 70'd0);
    chk("rst_valid", 70'(out_valid), 70'd0);
    chk("rst_done", 70'(done), 70'd0);
    @(negedge clk);
    rst = 1'b1;
    do_start(CFG_A);
    chk("nom_cfg_first", 70'(cfg_reg), 70'({4'd0, 2'd0, CFG_A}));
    chk("nom_busy", 70'(busy), 70'd1);
    wait_done("nom", 300);
    chk("nom_done_cycle", 70'(done_cyc - e0), 70'd122);
    chk("nom_done_count", 70'(dones), 70'd1);
    chk("nom_done_low", 70'(done), 70'd0);
    chk("nom_idle", 70'(busy), 70'd0);
    chk("nom_empty", 70'(out_valid), 70'd0);
    chk("nom_cfg_hold", 70'(cfg_reg), 70'({4'd9, 2'd3, CFG_A}));
    check_stream("nom");
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    do_start(CFG_B);
    repeat (80) @(posedge clk);
    #1;
    chk("bp_stall_pos", 70'(cfg_reg[31:26]), 70'({4'd6, 2'd1}));
    chk("bp_valid", 70'(out_valid), 70'd1);
    chk("bp_busy", 70'(busy), 70'd1);
    chk("bp_head", out_data, exp_entry(0));
    chk("bp_no_pops", 70'(got.size()), 70'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_still_stalled", 70'(cfg_reg[31:26]), 70'({4'd6, 2'd1}));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("fullpop_push_refused", 70'(cfg_reg[31:26]), 70'({4'd6, 2'd1}));
    @(posedge clk);
    #1;
    chk("fullpop_push_next", 70'(cfg_reg[31:26]), 70'({4'd7, 2'd1}));
    wait_done("bp", 300);
    chk("bp_done_count", 70'(dones), 70'd1);
    check_stream("bp");
    do_start(CFG_A);
    wait_pos("ign", {4'd5, 2'd0}, 100);
    @(posedge clk);
    #1;
    slice_cfg = CFG_B;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_cfg_kept", 70'(cfg_reg[25:0]), 70'(CFG_A));
    chk("ign_busy", 70'(busy), 70'd1);
    wait_done("ign", 300);
    chk("ign_done_count", 70'(dones), 70'd1);
    chk("ign_cfg_end", 70'(cfg_reg[25:0]), 70'(CFG_A));
    check_stream("ign");
    do_start(CFG_B);
    wait_pos("mid", {4'd7, 2'd1}, 200);
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_valid_before", 70'(out_valid), 70'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cfg", 70'(cfg_reg), 70'd0);
    chk("mid_rst_busy", 70'(busy), 70'd0);
    chk("mid_rst_valid", 70'(out_valid), 70'd0);
    chk("mid_rst_done", 70'(done), 70'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_stale", 70'(out_valid), 70'd0);
    out_ready = 1'b1;
    do_start(CFG_A);
    chk("re_cfg_first", 70'(cfg_reg), 70'({4'd0, 2'd0, CFG_A}));
    wait_done("re", 300);
    chk("re_done_cycle", 70'(done_cyc - e0), 70'd122);
    chk("re_done_count", 70'(dones), 70'd1);
    check_stream("re");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
